// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam logic [31:0] PC_RESET_ADDR  = 32'h0000_3000;
    localparam int          HDR_BYTES      = 2;
    localparam int          BYTES_PER_WORD = 4;

    function automatic logic accepts_bytes(input state_e s);
        logic r;
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/im_loader_byte_packer.sv
// Packs big-endian stream bytes into 32-bit words; pulses word_valid on the
// fourth byte with the completed word formed combinationally from that byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CW = $clog2(BYTES_PER_WORD);
    localparam int HW = (BYTES_PER_WORD - 1) * 8;
    localparam logic [CW-1:0] LAST_CNT = CW'(BYTES_PER_WORD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [HW-1:0] hist_q, hist_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Byte history and position-in-word counter update
    always_comb begin
        hist_d     = hist_q;
        cnt_d      = cnt_q;
        word_valid = 1'b0;
        word       = {hist_q, byte_in};
        if (clear) begin
            hist_d = '0;
            cnt_d  = '0;
        end else if (shift_en) begin
            hist_d     = {hist_q[HW-9:0], byte_in};
            cnt_d      = cnt_q + CNT_ONE;
            word_valid = (cnt_q == LAST_CNT);
        end else begin
            hist_d = hist_q;
            cnt_d  = cnt_q;
        end
    end

    // Packer state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Boot-time IM writer: length header, big-endian words, CPU held until done.
// Optional trailing XOR checksum byte when IM_LOADER_CHECKSUM_EN is defined.
module im_loader
    import loader_pkg::*;
#(
    parameter int AW        = 10,
    parameter int BASE_WORD = int'(PC_RESET_ADDR[11:2])
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    byte_data,
    input  logic          byte_valid,
    output logic          byte_ready,
    input  logic          start,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [AW:0]   words_loaded
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);
    localparam logic [AW:0] WL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] BASE_IDX = AW'(BASE_WORD);
`ifdef IM_LOADER_CHECKSUM_EN
    localparam state_e ST_AFTER_DATA = ST_CSUM;
`else
    localparam state_e ST_AFTER_DATA = ST_DONE;
`endif

    state_e        state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [AW:0]   wl_q, wl_d;
    logic          im_we_q, im_we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic          transfer_s;
    logic          word_valid_s;
    logic [31:0]   word_s;
    logic [15:0]   len_full_s;
    logic          last_word_s;

    assign byte_ready  = accepts_bytes(state_q) & ~start;
    assign transfer_s  = byte_valid & byte_ready;
    assign len_full_s  = {len_q[15:8], byte_data};
    assign last_word_s = (17'(wl_q + WL_ONE) == {1'b0, len_q});

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (start),
        .shift_en   (transfer_s & (state_q == ST_DATA)),
        .byte_in    (byte_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Load sequencing, word write generation and status decode
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wl_d    = wl_q;
        im_we_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (start) begin
            state_d = ST_LEN_HI;
            len_d   = 16'h0000;
            wl_d    = '0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
        end else begin
`ifdef IM_LOADER_CHECKSUM_EN
            if (transfer_s) begin
                csum_d = csum_q ^ byte_data;
            end else begin
                csum_d = csum_q;
            end
`endif
            case (state_q)
                ST_LEN_HI: begin
                    if (transfer_s) begin
                        len_d   = {byte_data, 8'h00};
                        state_d = ST_LEN_LO;
                    end else begin
                        state_d = ST_LEN_HI;
                    end
                end
                ST_LEN_LO: begin
                    if (transfer_s) begin
                        len_d = len_full_s;
                        if ({1'b0, len_full_s} > DEPTH_L) begin
                            state_d = ST_ERR;
                        end else if (len_full_s == 16'h0000) begin
                            state_d = ST_AFTER_DATA;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_LEN_LO;
                    end
                end
                ST_DATA: begin
                    if (word_valid_s) begin
                        im_we_d = 1'b1;
                        wdata_d = word_s;
                        waddr_d = BASE_IDX + wl_q[AW-1:0];
                        wl_d    = wl_q + WL_ONE;
                        state_d = last_word_s ? ST_AFTER_DATA : ST_DATA;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (transfer_s) begin
                        state_d = (byte_data == csum_q) ? ST_DONE : ST_ERR;
                    end else begin
                        state_d = ST_CSUM;
                    end
                end
`endif
                ST_DONE: state_d = ST_DONE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_ERR;
            endcase
        end
        cpu_hold_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LEN_HI;
            len_q      <= 16'h0000;
            wl_q       <= '0;
            im_we_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'h0000_0000;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wl_q       <= wl_d;
            im_we_q    <= im_we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign im_we        = im_we_q;
    assign im_waddr     = waddr_q;
    assign im_wdata     = wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = wl_q;

endmodule
